// File: rtl/dynamixel_pkg.sv
// Shared types and frame-timing constants for the Dynamixel sync-write scheduler.
package dynamixel_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      TRANSMIT = 2'd2,
      GUARD    = 2'd3
   } state_t;

   localparam int SYNC_WRITE_FRAME_BYTES = 34;
   localparam int UART_BITS_PER_BYTE     = 10;
   localparam int FRAME_MARGIN_CLOCKS    = 64;
   localparam int TIMER_W                = 16;

   function automatic int frame_clocks_default(input int clocks_per_bit);
      return SYNC_WRITE_FRAME_BYTES * UART_BITS_PER_BYTE * clocks_per_bit + FRAME_MARGIN_CLOCKS;
   endfunction

endpackage

// File: rtl/dynamixel_period_timer.sv
// Free-running schedule period counter; tick marks the last count before wrap.
module dynamixel_period_timer #(
   parameter int period_clocks = 500
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = (period_clocks > 1) ? $clog2(period_clocks) : 1;

   logic [CW-1:0] count;

   assign tick = enable && (count == CW'(period_clocks - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (!enable || tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/dynamixel_write_scheduler.sv
// Periodic launcher for the sync-write transmitter: shadows targets, pulses send, drives tx_enable.
// Optional DYNAMIXEL_KEEPALIVE_EN forces a resend after keepalive_ticks idle ticks.
//
// state    | meaning
// IDLE     | bus released, waiting for a tick with pending data
// START    | tx_enable already high; send pulse issued on exit
// TRANSMIT | frame on the wire, frame timer counting down
// GUARD    | frame done, bus still driven for the guard interval
module dynamixel_write_scheduler
   import dynamixel_pkg::*;
#(
   parameter int clocks_per_bit  = 1,
   parameter int period_clocks   = 500,
   parameter int frame_clocks    = frame_clocks_default(clocks_per_bit),
   parameter int guard_clocks    = 8,
   parameter int keepalive_ticks = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        update,
   input  logic [31:0] position1,
   input  logic [31:0] position2,
   input  logic [31:0] position3,
   input  logic [31:0] position4,
   output logic        send,
   output logic [31:0] shadow1,
   output logic [31:0] shadow2,
   output logic [31:0] shadow3,
   output logic [31:0] shadow4,
   output logic        tx_enable,
   output logic        busy,
   output logic [7:0]  overrun_count,
   output logic [15:0] frame_count
);

   state_t               state, state_next;
   logic [TIMER_W-1:0]   timer, timer_next;
   logic                 tick;
   logic                 launch;
   logic                 keepalive_due;
   logic                 dirty, dirty_next;
   logic                 send_next;
   logic                 tx_enable_next;
   logic [7:0]           overrun_next;
   logic [15:0]          frame_count_next;

   dynamixel_period_timer #(
      .period_clocks (period_clocks)
   ) u_period_timer (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

`ifdef DYNAMIXEL_KEEPALIVE_EN
   logic [15:0] idle_ticks;

   assign keepalive_due = (idle_ticks == 16'(keepalive_ticks));

   always_ff @(posedge clock) begin
      if (reset) begin
         idle_ticks <= '0;
      end else if (launch) begin
         idle_ticks <= '0;
      end else if (state == IDLE && tick) begin
         idle_ticks <= idle_ticks + 16'd1;
      end
   end
`else
   // Keepalive disabled: the comparison folds to 0 and keeps keepalive_ticks referenced.
   assign keepalive_due = (keepalive_ticks < 0);
`endif

   assign launch = (state == IDLE) && tick && (dirty || update || keepalive_due);
   assign busy   = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      case (state)
         IDLE: begin
            if (launch) state_next = START;
         end
         START: begin
            state_next = TRANSMIT;
            timer_next = TIMER_W'(frame_clocks - 1);
         end
         TRANSMIT: begin
            if (timer == '0) begin
               if (guard_clocks == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next = GUARD;
                  timer_next = TIMER_W'(guard_clocks - 1);
               end
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
         end
         GUARD: begin
            if (timer == '0) state_next = IDLE;
            else             timer_next = timer - TIMER_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   // Ticks that land while a frame is in flight are dropped; dirty keeps the data pending.
   always_comb begin
      send_next        = (state == START);
      tx_enable_next   = tx_enable;
      if (launch)                                      tx_enable_next = 1'b1;
      else if (state != IDLE && state_next == IDLE)    tx_enable_next = 1'b0;
      frame_count_next = frame_count + ((state == START) ? 16'd1 : 16'd0);
      overrun_next     = overrun_count;
      if (tick && state != IDLE && overrun_count != 8'hFF)
         overrun_next = overrun_count + 8'd1;
      dirty_next       = update | (dirty & ~launch);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         send          <= 1'b0;
         tx_enable     <= 1'b0;
         overrun_count <= '0;
         frame_count   <= '0;
         dirty         <= 1'b0;
         shadow1       <= '0;
         shadow2       <= '0;
         shadow3       <= '0;
         shadow4       <= '0;
      end else begin
         send          <= send_next;
         tx_enable     <= tx_enable_next;
         overrun_count <= overrun_next;
         frame_count   <= frame_count_next;
         dirty         <= dirty_next;
         if (launch) begin
            shadow1 <= position1;
            shadow2 <= position2;
            shadow3 <= position3;
            shadow4 <= position4;
         end
      end
   end

endmodule

// File: tb/tb_dynamixel_write_scheduler.sv
// Directed bench: instance a (period 40, frame 20, guard 4) for timing/data,
// instance o (period 12 < frame 16, guard 0) for overrun saturation and guard skip.
module tb_dynamixel_write_scheduler;

`ifdef DYNAMIXEL_KEEPALIVE_EN
   localparam bit KA = 1'b1;
`else
   localparam bit KA = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        a_reset, a_enable, a_update;
   logic [31:0] a_p1, a_p2, a_p3, a_p4;
   logic        a_send, a_tx, a_busy;
   logic [31:0] a_s1, a_s2, a_s3, a_s4;
   logic [7:0]  a_ovr;
   logic [15:0] a_fc;

   logic        o_reset, o_enable, o_update;
   logic [31:0] o_p1, o_p2, o_p3, o_p4;
   logic        o_send, o_tx, o_busy;
   logic [31:0] o_s1, o_s2, o_s3, o_s4;
   logic [7:0]  o_ovr;
   logic [15:0] o_fc;

   int checks = 0;
   int failures = 0;
   int k_a = 0;

   dynamixel_write_scheduler #(
      .clocks_per_bit(1), .period_clocks(40), .frame_clocks(20),
      .guard_clocks(4), .keepalive_ticks(4)
   ) dut_a (
      .clock(clock), .reset(a_reset), .enable(a_enable), .update(a_update),
      .position1(a_p1), .position2(a_p2), .position3(a_p3), .position4(a_p4),
      .send(a_send), .shadow1(a_s1), .shadow2(a_s2), .shadow3(a_s3), .shadow4(a_s4),
      .tx_enable(a_tx), .busy(a_busy), .overrun_count(a_ovr), .frame_count(a_fc)
   );

   dynamixel_write_scheduler #(
      .clocks_per_bit(1), .period_clocks(12), .frame_clocks(16),
      .guard_clocks(0), .keepalive_ticks(4)
   ) dut_o (
      .clock(clock), .reset(o_reset), .enable(o_enable), .update(o_update),
      .position1(o_p1), .position2(o_p2), .position3(o_p3), .position4(o_p4),
      .send(o_send), .shadow1(o_s1), .shadow2(o_s2), .shadow3(o_s3), .shadow4(o_s4),
      .tx_enable(o_tx), .busy(o_busy), .overrun_count(o_ovr), .frame_count(o_fc)
   );

   // k_a counts rising edges since reset release; observations are taken at negedges.
   task automatic goto_a(input int k);
      while (k_a < k) begin
         @(negedge clock);
         k_a++;
      end
   endtask

   task automatic reset_a();
      @(negedge clock);
      a_reset = 1'b1; a_enable = 1'b1; a_update = 1'b0;
      repeat (3) @(negedge clock);
      a_reset = 1'b0;
      k_a = 0;
   endtask

   task automatic pulse_update_a();
      a_update = 1'b1;
      goto_a(k_a + 1);
      a_update = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      a_reset = 1'b1; a_enable = 1'b1; a_update = 1'b1;
      a_p1 = 32'hDEAD_BEEF; a_p2 = 32'h1; a_p3 = 32'h2; a_p4 = 32'h3;
      repeat (3) @(negedge clock);
      checks++; if (a_send !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", a_send); end
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b exp=0", a_tx); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if (a_ovr !== 8'd0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", a_ovr); end
      checks++; if (a_fc !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", a_fc); end
      checks++; if ({a_s1, a_s2, a_s3, a_s4} !== 128'd0) begin failures++; $display("FAIL reset_shadows got=%h exp=0", {a_s1, a_s2, a_s3, a_s4}); end
      a_update = 1'b0;
      a_p1 = 32'h0; a_p2 = 32'h0; a_p3 = 32'h0; a_p4 = 32'h0;
   endtask

   task automatic test_idle_no_update();
      int sends = 0;
      int txs = 0;
      reset_a();
      for (int i = 0; i < 190; i++) begin
         goto_a(k_a + 1);
         if (a_send === 1'b1) sends++;
         if (a_tx === 1'b1) txs++;
      end
      checks++; if (sends != 0) begin failures++; $display("FAIL idle_send got=%0d exp=0", sends); end
      checks++; if (txs != 0) begin failures++; $display("FAIL idle_tx got=%0d exp=0", txs); end
      checks++; if (a_fc !== 16'd0) begin failures++; $display("FAIL idle_frame_count got=%0d exp=0", a_fc); end
   endtask

   task automatic test_first_frame();
      reset_a();
      a_p1 = 32'h0000_0800; a_p2 = 32'h0; a_p3 = 32'hA5; a_p4 = 32'h5A;
      goto_a(10);
      pulse_update_a();
      goto_a(39);
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL ff_tx_before got=%b exp=0", a_tx); end
      checks++; if (a_s1 !== 32'h0) begin failures++; $display("FAIL ff_shadow_before got=%h exp=0", a_s1); end
      goto_a(40);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL ff_tx_rise got=%b exp=1", a_tx); end
      checks++; if (a_send !== 1'b0) begin failures++; $display("FAIL ff_send_early got=%b exp=0", a_send); end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL ff_busy got=%b exp=1", a_busy); end
      checks++; if (a_s1 !== 32'h800 || a_s3 !== 32'hA5 || a_s4 !== 32'h5A) begin failures++; $display("FAIL ff_shadows got=%h/%h exp=800/a5", a_s1, a_s3); end
      goto_a(41);
      checks++; if (a_send !== 1'b1) begin failures++; $display("FAIL ff_send got=%b exp=1", a_send); end
      checks++; if (a_fc !== 16'd1) begin failures++; $display("FAIL ff_frame_count got=%0d exp=1", a_fc); end
      goto_a(42);
      checks++; if (a_send !== 1'b0) begin failures++; $display("FAIL ff_send_one_cycle got=%b exp=0", a_send); end
      goto_a(64);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL ff_tx_guard got=%b exp=1", a_tx); end
      goto_a(65);
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL ff_tx_fall got=%b exp=0", a_tx); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL ff_busy_end got=%b exp=0", a_busy); end
   endtask

   task automatic test_update_in_transmit();
      reset_a();
      a_p1 = 32'h800; a_p2 = 32'h0;
      goto_a(10);
      pulse_update_a();
      goto_a(45);
      a_p2 = 32'h1234;
      pulse_update_a();
      goto_a(50);
      checks++; if (a_s2 !== 32'h0) begin failures++; $display("FAIL uit_shadow_frozen got=%h exp=0", a_s2); end
      goto_a(64);
      checks++; if (a_s2 !== 32'h0) begin failures++; $display("FAIL uit_shadow_guard got=%h exp=0", a_s2); end
      goto_a(79);
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL uit_tx_before got=%b exp=0", a_tx); end
      goto_a(80);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL uit_tx_relaunch got=%b exp=1", a_tx); end
      checks++; if (a_s2 !== 32'h1234) begin failures++; $display("FAIL uit_shadow_new got=%h exp=1234", a_s2); end
      goto_a(81);
      checks++; if (a_send !== 1'b1) begin failures++; $display("FAIL uit_send got=%b exp=1", a_send); end
      checks++; if (a_fc !== 16'd2) begin failures++; $display("FAIL uit_frame_count got=%0d exp=2", a_fc); end
      checks++; if (a_ovr !== 8'd0) begin failures++; $display("FAIL uit_overrun got=%0d exp=0", a_ovr); end
   endtask

   task automatic test_enable_low_midframe();
      int txs = 0;
      reset_a();
      a_p2 = 32'h77;
      goto_a(10);
      pulse_update_a();
      goto_a(45);
      a_enable = 1'b0;
      a_p2 = 32'h99;
      pulse_update_a();
      goto_a(64);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL en_frame_continues got=%b exp=1", a_tx); end
      goto_a(65);
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL en_frame_done got=%b exp=0", a_busy); end
      while (k_a < 130) begin
         goto_a(k_a + 1);
         if (a_tx === 1'b1) txs++;
      end
      checks++; if (txs != 0) begin failures++; $display("FAIL en_no_launch got=%0d exp=0", txs); end
      checks++; if (a_fc !== 16'd1) begin failures++; $display("FAIL en_frame_count got=%0d exp=1", a_fc); end
      a_enable = 1'b1;
      goto_a(169);
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL en_tx_before got=%b exp=0", a_tx); end
      goto_a(170);
      checks++; if (a_tx !== 1'b1) begin failures++; $display("FAIL en_relaunch got=%b exp=1", a_tx); end
      checks++; if (a_s2 !== 32'h99) begin failures++; $display("FAIL en_shadow got=%h exp=99", a_s2); end
      goto_a(200);
   endtask

   task automatic test_reset_midframe();
      int sends = 0;
      reset_a();
      a_p1 = 32'hCAFE; a_p2 = 32'h0;
      goto_a(10);
      pulse_update_a();
      goto_a(50);
      a_reset = 1'b1;
      goto_a(51);
      a_reset = 1'b0;
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL rmf_tx got=%b exp=0", a_tx); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmf_busy got=%b exp=0", a_busy); end
      checks++; if (a_fc !== 16'd0) begin failures++; $display("FAIL rmf_frame_count got=%0d exp=0", a_fc); end
      checks++; if (a_s1 !== 32'h0) begin failures++; $display("FAIL rmf_shadow got=%h exp=0", a_s1); end
      while (k_a < 200) begin
         goto_a(k_a + 1);
         if (a_send === 1'b1 || a_tx === 1'b1) sends++;
      end
      checks++; if (sends != 0) begin failures++; $display("FAIL rmf_no_send got=%0d exp=0", sends); end
   endtask

   task automatic test_keepalive();
      reset_a();
      a_p1 = 32'h800; a_p2 = 32'h0;
      goto_a(10);
      pulse_update_a();
      goto_a(41);
      checks++; if (a_fc !== 16'd1) begin failures++; $display("FAIL ka_first got=%0d exp=1", a_fc); end
      goto_a(200);
      checks++; if (a_tx !== 1'b0) begin failures++; $display("FAIL ka_early got=%b exp=0", a_tx); end
      goto_a(240);
      checks++; if (a_tx !== KA) begin failures++; $display("FAIL ka_resend_tx got=%b exp=%b", a_tx, KA); end
      goto_a(241);
      checks++; if (a_send !== KA) begin failures++; $display("FAIL ka_resend_send got=%b exp=%b", a_send, KA); end
      checks++; if (a_s1 !== 32'h800) begin failures++; $display("FAIL ka_shadow got=%h exp=800", a_s1); end
      goto_a(300);
      checks++; if (a_fc !== (KA ? 16'd2 : 16'd1)) begin failures++; $display("FAIL ka_frame_count got=%0d exp=%0d", a_fc, KA ? 2 : 1); end
   endtask

   task automatic test_overrun_saturate();
      int kb = 0;
      int last_send = -1;
      logic prev_send = 1'b0;
      @(negedge clock);
      o_reset = 1'b1; o_enable = 1'b1; o_update = 1'b1;
      o_p1 = 32'h11; o_p2 = 32'h22; o_p3 = 32'h33; o_p4 = 32'h44;
      repeat (3) @(negedge clock);
      o_reset = 1'b0;
      while (kb < 6200) begin
         @(negedge clock);
         kb++;
         if (kb == 12) begin
            checks++; if (o_tx !== 1'b1) begin failures++; $display("FAIL ov_tx_rise got=%b exp=1", o_tx); end
         end
         if (kb == 28) begin
            checks++; if (o_tx !== 1'b1) begin failures++; $display("FAIL ov_tx_last got=%b exp=1", o_tx); end
         end
         if (kb == 29) begin
            checks++; if (o_tx !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL ov_guard_skip got=%b%b exp=00", o_tx, o_busy); end
         end
         if (kb == 23) begin
            checks++; if (o_ovr !== 8'd0) begin failures++; $display("FAIL ov_before_drop got=%0d exp=0", o_ovr); end
         end
         if (kb == 24) begin
            checks++; if (o_ovr !== 8'd1) begin failures++; $display("FAIL ov_first_drop got=%0d exp=1", o_ovr); end
         end
         if (kb == 6119) begin
            checks++; if (o_ovr !== 8'd254) begin failures++; $display("FAIL ov_254 got=%0d exp=254", o_ovr); end
         end
         if (kb == 6120) begin
            checks++; if (o_ovr !== 8'd255) begin failures++; $display("FAIL ov_255 got=%0d exp=255", o_ovr); end
         end
         if (o_send === 1'b1) begin
            if (last_send < 0) begin
               checks++; if (kb != 13) begin failures++; $display("FAIL ov_first_send got=%0d exp=13", kb); end
            end else begin
               checks++; if (kb - last_send != 24) begin failures++; $display("FAIL ov_send_spacing got=%0d exp=24", kb - last_send); end
            end
            checks++; if (prev_send === 1'b1) begin failures++; $display("FAIL ov_send_double got=1 exp=0"); end
            last_send = kb;
         end
         prev_send = o_send;
      end
      checks++; if (o_ovr !== 8'd255) begin failures++; $display("FAIL ov_hold got=%0d exp=255", o_ovr); end
      checks++; if (o_fc !== 16'd258) begin failures++; $display("FAIL ov_frame_count got=%0d exp=258", o_fc); end
      checks++; if (o_s3 !== 32'h33) begin failures++; $display("FAIL ov_shadow got=%h exp=33", o_s3); end
   endtask

   initial begin
      a_reset = 1'b1; a_enable = 1'b0; a_update = 1'b0;
      a_p1 = '0; a_p2 = '0; a_p3 = '0; a_p4 = '0;
      o_reset = 1'b1; o_enable = 1'b0; o_update = 1'b0;
      o_p1 = '0; o_p2 = '0; o_p3 = '0; o_p4 = '0;
      test_reset();
      test_idle_no_update();
      test_first_frame();
      test_update_in_transmit();
      test_enable_low_midframe();
      test_reset_midframe();
      test_keepalive();
      test_overrun_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
